// File: rtl/tdm_serializer.sv
// ---------------------------------------------------------------------------
// tdm_serializer
//   Parallel-to-TDM serializer for the DAC output path. Whole frames of
//   CHANNELS x WORD_W samples arrive over a valid/ready handshake into a
//   shadow buffer. At each frame boundary the shadow is promoted to the
//   active frame, and the active frame is sent MSB-first, one bit per
//   bclk_en strobe, with a frame sync that is high for the first FS_LEN bits.
//   If no new frame is available at a boundary, the previous frame is
//   repeated and retrans_incr pulses.
//
//   Handshake: a frame is transferred on every clk edge where
//   in_valid && in_ready. in_ready is high exactly when the shadow buffer is
//   empty. While in_ready is low, in_valid and pdata are ignored, so the
//   source must hold them until the transfer.
//
// Parameters
//   CHANNELS  TDM slots per frame (1..16)
//   WORD_W    bits per slot (8..32)
//   FS_LEN    fs high time in bits (1..CHANNELS*WORD_W-1)
//
// Ports
//   clk           system clock
//   rst           synchronous reset, active high
//   enable        run serializer; low forces fs/tdmout low and rewinds to bit 0
//   bclk_en       one-clk strobe per TDM bit period
//   in_valid      pdata holds a frame
//   in_ready      shadow buffer empty
//   pdata         frame; channel n = pdata[n*WORD_W +: WORD_W]
//   chan_mute     per-slot mute, 1 = slot driven as 0 (TDM_CHMUTE_EN only)
//   fs            TDM frame sync
//   tdmout        TDM serial data
//   frame_start   1-clk pulse when bit 0 of a frame is driven
//   retrans_incr  1-clk pulse when a frame is repeated because of underrun
//
// Optional feature
//   Define TDM_CHMUTE_EN to add the chan_mute port and per-slot muting.
// ---------------------------------------------------------------------------
module tdm_serializer #(
  parameter int CHANNELS = 8,
  parameter int WORD_W   = 32,
  parameter int FS_LEN   = 128
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         bclk_en,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*WORD_W-1:0]   pdata,
`ifdef TDM_CHMUTE_EN
  input  logic [CHANNELS-1:0]          chan_mute,
`endif
  output logic                         fs,
  output logic                         tdmout,
  output logic                         frame_start,
  output logic                         retrans_incr
);

  localparam int FRAME_BITS = CHANNELS * WORD_W;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int SLOT_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int BPOS_W     = $clog2(WORD_W);

  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0]  FS_LIMIT = CNT_W'(FS_LEN);
  localparam logic [CNT_W-1:0]  WORD_W_C = CNT_W'(WORD_W);
  localparam logic [BPOS_W-1:0] WORD_MSB = BPOS_W'(WORD_W - 1);

  // Position within the frame. slot_q/bpos_q track bit_cnt_q
  // (slot = bit_cnt / WORD_W, bpos = WORD_W-1 - bit_cnt % WORD_W) so no
  // divider is needed when WORD_W is not a power of two.
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [SLOT_W-1:0]     slot_q;
  logic [BPOS_W-1:0]     bpos_q;

  logic [FRAME_BITS-1:0] shadow_q;
  logic                  shadow_valid_q;
  // Active frame. Bits are picked by index rather than shifted out, so this
  // register still holds the whole frame at the end and serves directly as
  // the copy that is repeated on underrun.
  logic [FRAME_BITS-1:0] frame_q;

  logic                  fs_q;
  logic                  tdm_q;
  logic                  frame_start_q;
  logic                  retrans_q;

  logic                  strobe;
  logic                  boundary;
  logic                  accept;
  logic                  underrun;
  logic [FRAME_BITS-1:0] frame_src;
  logic [CNT_W-1:0]      bit_idx;
  logic                  slot_muted;

  assign strobe   = enable && bclk_en;
  assign boundary = strobe && (bit_cnt_q == '0);
  assign in_ready = !shadow_valid_q;
  assign accept   = in_valid && in_ready;

  // Frame that supplies the bit emitted on this strobe. At a boundary the
  // incoming frame is used directly so its first bit appears one clk after
  // the boundary strobe, whether it comes from the shadow or bypasses it.
  always_comb begin
    frame_src = frame_q;
    underrun  = 1'b0;
    if (boundary) begin
      if (shadow_valid_q) begin
        frame_src = shadow_q;
      end else if (accept) begin
        frame_src = pdata;
      end else begin
        underrun = 1'b1;
      end
    end
  end

  assign bit_idx = (CNT_W'(slot_q) * WORD_W_C) + CNT_W'(bpos_q);

`ifdef TDM_CHMUTE_EN
  assign slot_muted = chan_mute[slot_q];
`else
  assign slot_muted = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q      <= '0;
      slot_q         <= '0;
      bpos_q         <= WORD_MSB;
      shadow_q       <= '0;
      shadow_valid_q <= 1'b0;
      frame_q        <= '0;
      fs_q           <= 1'b0;
      tdm_q          <= 1'b0;
      frame_start_q  <= 1'b0;
      retrans_q      <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      retrans_q     <= 1'b0;

      // Bit engine. Disable has priority over a coincident strobe.
      if (!enable) begin
        bit_cnt_q <= '0;
        slot_q    <= '0;
        bpos_q    <= WORD_MSB;
        fs_q      <= 1'b0;
        tdm_q     <= 1'b0;
      end else if (strobe) begin
        fs_q          <= (bit_cnt_q < FS_LIMIT);
        tdm_q         <= frame_src[bit_idx] & ~slot_muted;
        frame_start_q <= boundary;
        retrans_q     <= underrun;
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_q <= '0;
          slot_q    <= '0;
          bpos_q    <= WORD_MSB;
        end else begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bpos_q == '0) begin
            slot_q <= slot_q + 1'b1;
            bpos_q <= WORD_MSB;
          end else begin
            bpos_q <= bpos_q - 1'b1;
          end
        end
      end

      // Buffering. A boundary always empties the shadow; on underrun
      // frame_src equals frame_q, so the active frame is simply kept.
      if (boundary) begin
        frame_q        <= frame_src;
        shadow_valid_q <= 1'b0;
      end else if (accept) begin
        shadow_q       <= pdata;
        shadow_valid_q <= 1'b1;
      end
    end
  end

  assign fs           = fs_q;
  assign tdmout       = tdm_q;
  assign frame_start  = frame_start_q;
  assign retrans_incr = retrans_q;

endmodule

// File: tb/tb_tdm_serializer.sv
// ---------------------------------------------------------------------------
// tb_tdm_serializer
//   Self-checking bench for tdm_serializer with default parameters
//   (8 x 32-bit slots, FS_LEN 128). Frames are pushed to an expected queue
//   when the DUT accepts them and popped at each frame start; a boundary
//   with an empty queue expects the previous frame again plus a retrans
//   pulse. The mute scenario runs only when TDM_CHMUTE_EN is defined.
// ---------------------------------------------------------------------------
module tb_tdm_serializer;

  localparam int CH  = 8;
  localparam int W   = 32;
  localparam int FSL = 128;
  localparam int FB  = CH * W;

  logic          clk;
  logic          rst;
  logic          enable;
  logic          bclk_en;
  logic          in_valid;
  logic          in_ready;
  logic [FB-1:0] pdata;
  logic [CH-1:0] mute_cfg;
  logic          fs;
  logic          tdmout;
  logic          frame_start;
  logic          retrans_incr;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rt_cnt   = 0;

  // Bit clock: periodic strobe every bclk_div clks, or manual drive.
  int   bclk_div  = 2;
  bit   bclk_auto = 1'b1;
  logic bclk_man  = 1'b0;
  logic bclk_gen  = 1'b0;
  int   bclk_cnt  = 0;
  assign bclk_en = bclk_auto ? bclk_gen : bclk_man;

  // Scoreboard
  logic [FB-1:0] exp_q[$];
  logic [FB-1:0] last_frame = '0;
  logic [FB-1:0] fs_mask;

  tdm_serializer #(
    .CHANNELS (CH),
    .WORD_W   (W),
    .FS_LEN   (FSL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .bclk_en      (bclk_en),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .pdata        (pdata),
`ifdef TDM_CHMUTE_EN
    .chan_mute    (mute_cfg),
`endif
    .fs           (fs),
    .tdmout       (tdmout),
    .frame_start  (frame_start),
    .retrans_incr (retrans_incr)
  );

  // ---------------- clock / reset / background ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      bclk_cnt++;
      bclk_gen = ((bclk_cnt % bclk_div) == 0);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #3;
      cyc++;
      if (retrans_incr === 1'b1) rt_cnt++;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  // Advance one clk; report whether that edge carried a strobe.
  task automatic tick(output bit strobed);
    strobed = (enable === 1'b1) && (bclk_en === 1'b1);
    @(posedge clk);
    #2;
  endtask

  function automatic logic [FB-1:0] rand_frame();
    logic [FB-1:0] r;
    for (int i = 0; i < FB / 32; i++) r[i*32 +: 32] = $urandom_range(32'hFFFF_FFFF, 0);
    return r;
  endfunction

  // Serial order of a frame: ch0 MSB first ... ch(CH-1) LSB last, packed so
  // that bit b of the stream sits at index FB-1-b.
  function automatic logic [FB-1:0] to_stream(input logic [FB-1:0] f, input logic [CH-1:0] m);
    logic [FB-1:0] r;
    logic [W-1:0]  word;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      word = m[c] ? '0 : f[c*W +: W];
      r[FB-1-c*W -: W] = word;
    end
    return r;
  endfunction

  task automatic next_expected(output logic [FB-1:0] f, output logic rt);
    if (exp_q.size() > 0) begin
      f  = exp_q.pop_front();
      rt = 1'b0;
    end else begin
      f  = last_frame;
      rt = 1'b1;
    end
    last_frame = f;
  endtask

  // Driver: offer a frame until accepted; push to the scoreboard on accept.
  task automatic send_frame(input logic [FB-1:0] f, input int budget, output bit ok, output int acc_cyc);
    bit s;
    int n;
    n        = 0;
    acc_cyc  = -1;
    pdata    = f;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < budget) begin
      tick(s);
      n++;
    end
    ok = (in_ready === 1'b1);
    if (ok) begin
      tick(s);
      exp_q.push_back(f);
      acc_cyc = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_frame_start(input int budget, output bit ok, output int strobes,
                                  output logic rt, output int at_cyc);
    bit s;
    int n;
    n = 0; ok = 1'b0; strobes = 0; rt = 1'b0; at_cyc = -1;
    while (!ok && n < budget) begin
      tick(s);
      n++;
      if (s) strobes++;
      if (frame_start === 1'b1) begin
        ok     = 1'b1;
        rt     = retrans_incr;
        at_cyc = cyc;
      end
    end
  endtask

  // Called right after frame_start is seen: tdmout currently holds bit 0.
  task automatic capture_frame(output logic [FB-1:0] stream, output logic [FB-1:0] fs_bits,
                               output int hold_err, output bit ok);
    bit   s;
    int   b;
    int   n;
    logic pt;
    logic pf;
    stream = '0; fs_bits = '0; hold_err = 0; b = 1; n = 0;
    stream[FB-1]  = tdmout;
    fs_bits[FB-1] = fs;
    pt = tdmout;
    pf = fs;
    while (b < FB && n < FB * 16) begin
      tick(s);
      n++;
      if (s) begin
        stream[FB-1-b]  = tdmout;
        fs_bits[FB-1-b] = fs;
        pt = tdmout;
        pf = fs;
        b++;
      end else if (tdmout !== pt || fs !== pf) begin
        hold_err++;
      end
    end
    ok = (b == FB);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit s, ok;
    int acc, ns, fc, he;
    logic rt, ert;
    logic [FB-1:0] st, fb, ef;
    rst = 1'b1; enable = 1'b1; in_valid = 1'b1; pdata = rand_frame();
    repeat (3) tick(s);
    checks++; if (fs !== 1'b0) begin failures++; $display("FAIL reset_fs got=%b exp=0", fs); end
    checks++; if (tdmout !== 1'b0) begin failures++; $display("FAIL reset_tdmout got=%b exp=0", tdmout); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (retrans_incr !== 1'b0) begin failures++; $display("FAIL reset_retrans got=%b exp=0", retrans_incr); end
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_frame_start got=%b exp=0", frame_start); end

    // A shadow frame pending at reset must be discarded.
    rst = 1'b0; enable = 1'b0; in_valid = 1'b0;
    send_frame(rand_frame(), 20, ok, acc);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL preload_in_ready got=%b exp=0", in_ready); end
    rst = 1'b1;
    exp_q.delete();
    last_frame = '0;
    repeat (3) tick(s);
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_drop_shadow got=%b exp=1", in_ready); end

    enable = 1'b1;
    wait_frame_start(64, ok, ns, rt, fc);
    next_expected(ef, ert);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL post_reset_frame_timeout got=%b exp=1", ok); end
    checks++; if (rt !== ert) begin failures++; $display("FAIL post_reset_retrans got=%b exp=%b", rt, ert); end
    capture_frame(st, fb, he, ok);
    checks++; if (st !== to_stream(ef, mute_cfg)) begin failures++; $display("FAIL post_reset_zero_frame got=%h exp=%h", st, to_stream(ef, mute_cfg)); end
    enable = 1'b0;
    tick(s);
  endtask

  int fc_basic;

  task automatic test_basic();
    bit s, ok;
    int acc, ns, fc, he;
    logic rt, ert;
    logic [FB-1:0] f1, st, fb, ef;
    bclk_div = 4;
    f1 = '0;
    f1[31:0] = 32'h8000_0001;
    send_frame(f1, 20, ok, acc);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL basic_accept got=%b exp=1", ok); end
    enable = 1'b1;
    wait_frame_start(64, ok, ns, rt, fc);
    fc_basic = fc;
    next_expected(ef, ert);
    checks++; if (ns !== 1) begin failures++; $display("FAIL basic_first_strobe_boundary got=%0d exp=1", ns); end
    checks++; if (rt !== ert) begin failures++; $display("FAIL basic_retrans got=%b exp=%b", rt, ert); end
    capture_frame(st, fb, he, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL basic_capture_timeout got=%b exp=1", ok); end
    checks++; if (st !== to_stream(ef, mute_cfg)) begin failures++; $display("FAIL basic_stream got=%h exp=%h", st, to_stream(ef, mute_cfg)); end
    checks++; if (fb !== fs_mask) begin failures++; $display("FAIL basic_fs got=%h exp=%h", fb, fs_mask); end
    checks++; if (he !== 0) begin failures++; $display("FAIL basic_hold_between_strobes got=%0d exp=0", he); end
  endtask

  task automatic test_underrun();
    bit ok;
    int ns, fc, he, rc0;
    logic rt, ert;
    logic [FB-1:0] st, fb, ef;
    rc0 = rt_cnt;
    wait_frame_start(64, ok, ns, rt, fc);
    next_expected(ef, ert);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL underrun_frame_timeout got=%b exp=1", ok); end
    checks++; if (rt !== ert) begin failures++; $display("FAIL underrun_retrans got=%b exp=%b", rt, ert); end
    checks++; if (fc - fc_basic !== 1024) begin failures++; $display("FAIL frame_period got=%0d exp=1024", fc - fc_basic); end
    capture_frame(st, fb, he, ok);
    checks++; if (st !== to_stream(ef, mute_cfg)) begin failures++; $display("FAIL underrun_repeat got=%h exp=%h", st, to_stream(ef, mute_cfg)); end
    checks++; if (rt_cnt - rc0 !== 1) begin failures++; $display("FAIL retrans_pulse_width got=%0d exp=1", rt_cnt - rc0); end
  endtask

  task automatic test_back_to_back();
    bit s, ok2, ok3, w1, w2, c1, c2;
    int acc2, acc3, ns1, ns2, fca, fcb, he1, he2;
    logic rt1, rt2, ert1, ert2, rdy2;
    logic [FB-1:0] f2, f3, st1, st2, fb1, fb2, e1, e2;
    bclk_div = 2;
    repeat (40) tick(s);
    f2 = rand_frame();
    f3 = rand_frame();
    rdy2 = 1'bx;
    fork
      begin
        send_frame(f2, 100, ok2, acc2);
        rdy2 = in_ready;
        send_frame(f3, 2000, ok3, acc3);
      end
      begin
        wait_frame_start(1200, w1, ns1, rt1, fca);
        next_expected(e1, ert1);
        capture_frame(st1, fb1, he1, c1);
        wait_frame_start(100, w2, ns2, rt2, fcb);
        next_expected(e2, ert2);
        capture_frame(st2, fb2, he2, c2);
      end
    join
    checks++; if (rdy2 !== 1'b0) begin failures++; $display("FAIL b2b_ready_low got=%b exp=0", rdy2); end
    checks++; if (ok3 !== 1'b1) begin failures++; $display("FAIL b2b_second_accept got=%b exp=1", ok3); end
    checks++; if (acc3 !== fca + 1) begin failures++; $display("FAIL b2b_second_accept_cycle got=%0d exp=%0d", acc3, fca + 1); end
    checks++; if (rt1 !== ert1) begin failures++; $display("FAIL b2b_retrans_first got=%b exp=%b", rt1, ert1); end
    checks++; if (st1 !== to_stream(e1, mute_cfg)) begin failures++; $display("FAIL b2b_first_frame got=%h exp=%h", st1, to_stream(e1, mute_cfg)); end
    checks++; if (rt2 !== ert2) begin failures++; $display("FAIL b2b_retrans_second got=%b exp=%b", rt2, ert2); end
    checks++; if (st2 !== to_stream(e2, mute_cfg)) begin failures++; $display("FAIL b2b_second_frame got=%h exp=%h", st2, to_stream(e2, mute_cfg)); end
  endtask

  task automatic test_bypass();
    bit s, ok;
    int he;
    logic ert;
    logic [FB-1:0] f4, st, fb, ef;
    f4 = '1;
    enable = 1'b0; bclk_auto = 1'b0; bclk_man = 1'b0;
    tick(s);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bypass_shadow_empty got=%b exp=1", in_ready); end
    enable = 1'b1; bclk_man = 1'b1; in_valid = 1'b1; pdata = f4;
    tick(s);
    exp_q.push_back(f4);
    in_valid = 1'b0; bclk_man = 1'b0; bclk_auto = 1'b1;
    next_expected(ef, ert);
    checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL bypass_frame_start got=%b exp=1", frame_start); end
    checks++; if (retrans_incr !== ert) begin failures++; $display("FAIL bypass_retrans got=%b exp=%b", retrans_incr, ert); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bypass_shadow_stays_empty got=%b exp=1", in_ready); end
    capture_frame(st, fb, he, ok);
    checks++; if (st !== to_stream(ef, mute_cfg)) begin failures++; $display("FAIL bypass_stream got=%h exp=%h", st, to_stream(ef, mute_cfg)); end
  endtask

  task automatic test_disable();
    bit s, ok;
    int ns, fc, he, cnt, n, bad, acc;
    logic rt, ert;
    logic [FB-1:0] f5, st, fb, ef;
    bclk_div = 2;
    wait_frame_start(600, ok, ns, rt, fc);
    next_expected(ef, ert);
    checks++; if (rt !== ert) begin failures++; $display("FAIL disable_pre_retrans got=%b exp=%b", rt, ert); end
    cnt = 0; n = 0;
    while (cnt < 77 && n < 1000) begin
      tick(s);
      n++;
      if (s) cnt++;
    end
    // Previous frame is all ones and bit 77 is inside the fs window.
    checks++; if ({fs, tdmout} !== 2'b11) begin failures++; $display("FAIL bit77_state got=%b exp=11", {fs, tdmout}); end
    n = 0;
    while (bclk_en !== 1'b1 && n < 10) begin
      tick(s);
      n++;
    end
    enable = 1'b0;
    tick(s);
    checks++; if ({fs, tdmout, frame_start} !== 3'b000) begin failures++; $display("FAIL disable_wins got=%b exp=000", {fs, tdmout, frame_start}); end
    bad = 0;
    repeat (10) begin
      tick(s);
      if (fs !== 1'b0 || tdmout !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL disabled_idle got=%0d exp=0", bad); end
    f5 = rand_frame();
    send_frame(f5, 20, ok, acc);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL disabled_accept got=%b exp=0", in_ready); end
    enable = 1'b1;
    wait_frame_start(20, ok, ns, rt, fc);
    next_expected(ef, ert);
    checks++; if (ns !== 1) begin failures++; $display("FAIL reenable_boundary got=%0d exp=1", ns); end
    checks++; if (rt !== ert) begin failures++; $display("FAIL reenable_retrans got=%b exp=%b", rt, ert); end
    capture_frame(st, fb, he, ok);
    checks++; if (st !== to_stream(ef, mute_cfg)) begin failures++; $display("FAIL reenable_stream got=%h exp=%h", st, to_stream(ef, mute_cfg)); end
    checks++; if (fb !== fs_mask) begin failures++; $display("FAIL reenable_fs got=%h exp=%h", fb, fs_mask); end
  endtask

`ifdef TDM_CHMUTE_EN
  task automatic test_mute();
    bit s, ok;
    int ns, fc, he, acc;
    logic rt, ert;
    logic [FB-1:0] f6, st, fb, ef;
    repeat (20) tick(s);
    mute_cfg = 8'h02;
    f6 = '1;
    send_frame(f6, 20, ok, acc);
    wait_frame_start(1200, ok, ns, rt, fc);
    next_expected(ef, ert);
    checks++; if (rt !== ert) begin failures++; $display("FAIL mute_retrans got=%b exp=%b", rt, ert); end
    capture_frame(st, fb, he, ok);
    checks++; if (st !== to_stream(ef, mute_cfg)) begin failures++; $display("FAIL mute_stream got=%h exp=%h", st, to_stream(ef, mute_cfg)); end
    checks++; if (fb !== fs_mask) begin failures++; $display("FAIL mute_fs got=%h exp=%h", fb, fs_mask); end
    mute_cfg = '0;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; enable = 1'b0; in_valid = 1'b0; pdata = '0; mute_cfg = '0;
    for (int b = 0; b < FB; b++) fs_mask[FB-1-b] = (b < FSL);
    test_reset();
    test_basic();
    test_underrun();
    test_back_to_back();
    test_bypass();
    test_disable();
`ifdef TDM_CHMUTE_EN
    test_mute();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
